// File: rtl/accelerator_matrix_stream_driver_pkg.sv
// Shared types for the matrix stream driver: FSM states, bit constants and the
// {matrix, vector, scalar} enable-class encoding also used by the stream collector.
package accelerator_matrix_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        WAIT  = 2'd3
    } stream_state_t;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    // Enable class bit order is {matrix, vector, scalar}.
    localparam logic [2:0] CLASS_ROW    = 3'b111;
    localparam logic [2:0] CLASS_VECTOR = 3'b011;
    localparam logic [2:0] CLASS_SCALAR = 3'b001;

    function automatic logic [2:0] enable_class(input logic k_zero, input logic j_zero);
        if (k_zero && j_zero) begin
            return CLASS_ROW;
        end else if (k_zero) begin
            return CLASS_VECTOR;
        end else begin
            return CLASS_SCALAR;
        end
    endfunction

endpackage

// File: rtl/accelerator_matrix_stream_driver_if.sv
// Matrix stream handshake: the producer (master) drives element data plus
// position strobes, the consumer (slave) answers with request strobes.
interface accelerator_matrix_stream_driver_if #(
    parameter int DATA_SIZE = 64
);
    // Handshake: each element is presented by a 1-cycle DATA_OUT_*_ENABLE pulse
    // with DATA_OUT held until the next element; the consumer asks for the next
    // element with a 1-cycle REQUEST_*_ENABLE pulse whose class names that
    // element's position. Requests are only honoured while the producer waits.
    logic                 REQUEST_MATRIX_ENABLE;
    logic                 REQUEST_VECTOR_ENABLE;
    logic                 REQUEST_SCALAR_ENABLE;
    logic                 DATA_OUT_MATRIX_ENABLE;
    logic                 DATA_OUT_VECTOR_ENABLE;
    logic                 DATA_OUT_SCALAR_ENABLE;
    logic [DATA_SIZE-1:0] DATA_OUT;

    modport master (
        input  REQUEST_MATRIX_ENABLE,
        input  REQUEST_VECTOR_ENABLE,
        input  REQUEST_SCALAR_ENABLE,
        output DATA_OUT_MATRIX_ENABLE,
        output DATA_OUT_VECTOR_ENABLE,
        output DATA_OUT_SCALAR_ENABLE,
        output DATA_OUT
    );

    modport slave (
        output REQUEST_MATRIX_ENABLE,
        output REQUEST_VECTOR_ENABLE,
        output REQUEST_SCALAR_ENABLE,
        input  DATA_OUT_MATRIX_ENABLE,
        input  DATA_OUT_VECTOR_ENABLE,
        input  DATA_OUT_SCALAR_ENABLE,
        input  DATA_OUT
    );

endinterface

// File: rtl/accelerator_matrix_stream_driver_buffer.sv
// accelerator_stream_buffer: 1W1R synchronous RAM, one-cycle read latency;
// a read colliding with a write to the same address returns the old word.
module accelerator_stream_buffer #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic                    CLK,
    input  logic                    WRITE_ENABLE,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic                    READ_ENABLE,
    input  logic [ADDRESS_SIZE-1:0] READ_ADDRESS,
    output logic [DATA_SIZE-1:0]    READ_DATA
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;

    logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

    // Both accesses sample the array before this edge's update lands.
    always_ff @(posedge CLK) begin
        if (WRITE_ENABLE) begin
            mem[WRITE_ADDRESS] <= WRITE_DATA;
        end
        if (READ_ENABLE) begin
            READ_DATA <= mem[READ_ADDRESS];
        end
    end

endmodule

// File: rtl/accelerator_matrix_stream_driver.sv
// Matrix stream source: buffers a host-loaded matrix and replays it in i/j/k order,
// one element per consumer request. Optional checker: MATRIX_STREAM_DRIVER_CHECK_EN.
module accelerator_matrix_stream_driver
    import accelerator_matrix_stream_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic                    WRITE_ENABLE,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    input  logic [DATA_SIZE-1:0]    LENGTH_IN,
    accelerator_matrix_stream_driver_if.master stream,
    output logic                    ERROR,
    output stream_state_t           DEBUG_STATE
);

    localparam logic [DATA_SIZE-1:0] DIM_MAX = DATA_SIZE'(1) << CONTROL_SIZE;

    // Dimensions are held as their last index so a full 2**CONTROL_SIZE fits.
    function automatic logic [CONTROL_SIZE-1:0] last_index(input logic [DATA_SIZE-1:0] size);
        if (size >= DIM_MAX) begin
            return '1;
        end else begin
            return CONTROL_SIZE'(size - DATA_SIZE'(1));
        end
    endfunction

    stream_state_t state_q, state_d;

    logic [CONTROL_SIZE-1:0] i_q, j_q, k_q;
    logic [CONTROL_SIZE-1:0] i_n, j_n, k_n;
    logic [CONTROL_SIZE-1:0] si_last_q, sj_last_q, l_last_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0]    rd_data;
    logic [DATA_SIZE-1:0]    data_q;
    logic [2:0]              strobe_q;
    logic [2:0]              req_bits;
    logic                    ready_q;

    logic size_zero, req_any, k_wrap, j_wrap, last_elem;
    logic start_accept, start_zero, fetch, emit, advance;

    assign req_bits  = {stream.REQUEST_MATRIX_ENABLE,
                        stream.REQUEST_VECTOR_ENABLE,
                        stream.REQUEST_SCALAR_ENABLE};
    assign req_any   = |req_bits;
    assign size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (LENGTH_IN == '0);

    assign k_wrap    = (k_q == l_last_q);
    assign j_wrap    = (j_q == sj_last_q);
    assign last_elem = k_wrap && j_wrap && (i_q == si_last_q);

    assign k_n = k_wrap ? '0 : k_q + 1'b1;
    assign j_n = k_wrap ? (j_wrap ? '0 : j_q + 1'b1) : j_q;
    assign i_n = (k_wrap && j_wrap) ? i_q + 1'b1 : i_q;

    accelerator_stream_buffer #(
        .DATA_SIZE   (DATA_SIZE),
        .ADDRESS_SIZE(ADDRESS_SIZE)
    ) u_buffer (
        .CLK          (CLK),
        .WRITE_ENABLE (WRITE_ENABLE),
        .WRITE_ADDRESS(WRITE_ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .READ_ENABLE  (fetch),
        .READ_ADDRESS (addr_q),
        .READ_DATA    (rd_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_accept = ZERO;
        start_zero   = ZERO;
        fetch        = ZERO;
        emit         = ZERO;
        advance      = ZERO;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (size_zero) begin
                        start_zero = ONE;
                    end else begin
                        start_accept = ONE;
                        state_d      = FETCH;
                    end
                end
            end
            FETCH: begin
                fetch   = ONE;
                state_d = EMIT;
            end
            EMIT: begin
                emit    = ONE;
                state_d = last_elem ? IDLE : WAIT;
            end
            WAIT: begin
                if (req_any) begin
                    advance = ONE;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            si_last_q <= '0;
            sj_last_q <= '0;
            l_last_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            ready_q   <= ZERO;
        end else begin
            strobe_q <= '0;
            ready_q  <= (start_zero || (emit && last_elem)) ? ONE : ZERO;
            if (start_accept) begin
                si_last_q <= last_index(SIZE_I_IN);
                sj_last_q <= last_index(SIZE_J_IN);
                l_last_q  <= last_index(LENGTH_IN);
                i_q       <= '0;
                j_q       <= '0;
                k_q       <= '0;
                addr_q    <= '0;
            end
            if (emit) begin
                data_q   <= rd_data;
                strobe_q <= enable_class(k_q == '0, j_q == '0);
            end
            // Address wraps with the RAM depth, so long streams reread the buffer.
            if (advance) begin
                i_q    <= i_n;
                j_q    <= j_n;
                k_q    <= k_n;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

`ifdef MATRIX_STREAM_DRIVER_CHECK_EN
    logic err_q;
    logic violation;

    // A request must name the class of the element it asks for; any request
    // while fetching or emitting is a protocol error too. The stream advances anyway.
    always_comb begin
        violation = ZERO;
        if (state_q == WAIT && req_any && (req_bits != enable_class(k_n == '0, j_n == '0))) begin
            violation = ONE;
        end
        if ((state_q == FETCH || state_q == EMIT) && req_any) begin
            violation = ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= ZERO;
        end else if (state_q == IDLE && START) begin
            err_q <= ZERO;
        end else if (violation) begin
            err_q <= ONE;
        end
    end

    assign ERROR = err_q;
`else
    assign ERROR = ZERO;
`endif

    assign stream.DATA_OUT               = data_q;
    assign stream.DATA_OUT_MATRIX_ENABLE = strobe_q[2];
    assign stream.DATA_OUT_VECTOR_ENABLE = strobe_q[1];
    assign stream.DATA_OUT_SCALAR_ENABLE = strobe_q[0];
    assign READY                         = ready_q;
    assign DEBUG_STATE                   = state_q;

endmodule
